// File: rtl/frame_read_arbiter.sv
// frame_read_arbiter: shares one single-port frame RAM between the video
// scanout (2x scaled, never stalled) and a secondary game-logic reader.
// Video owns every even-column visible cycle; the secondary requester takes
// the remaining cycles through a small IDLE/ISSUE/CAPTURE FSM.
//
// Optional build macro FRAME_ARB_BLANK_ONLY_EN: when defined, the secondary
// requester is only granted while the display is outside its visible region.
//
// Secondary handshake: sec_req is level-held with sec_addr stable until the
// request is accepted (IDLE->ISSUE). sec_ack is a one-cycle pulse and sec_data
// is valid in that same cycle; sec_data holds its value until the next ack.
// A requester keeping sec_req high in the cycle after sec_ack starts a new
// transaction.
module frame_read_arbiter #(
    parameter int FB_W = 320,
    parameter int FB_H = 240
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        vid_active,
    input  logic [9:0]  drawX,
    input  logic [9:0]  drawY,
    output logic [1:0]  vid_pixel,
    input  logic        sec_req,
    input  logic [17:0] sec_addr,
    output logic        sec_ack,
    output logic [1:0]  sec_data,
    output logic [17:0] ram_addr,
    input  logic [1:0]  ram_data,
    output logic [1:0]  sec_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2
    } sec_state_t;

    // Frame size kept one bit wider so FB_W*FB_H == 2^18 still compares correctly.
    localparam logic [18:0] FB_SIZE = 19'(FB_W * FB_H);

    sec_state_t  state;
    sec_state_t  state_next;
    logic        accept;
    logic        video_slot;
    logic        sec_slot_free;
    logic        sec_grant;
    logic [17:0] vid_addr;
    logic [17:0] sec_addr_q;
    logic        oob_q;
    logic [17:0] ram_addr_q;
    logic [1:0]  sec_data_q;
    logic        vid_v1;
    logic        act_d1;
    logic        unused_bits;

    // The row LSB is dropped by the 2x vertical scaling.
    assign unused_bits = drawY[0];

    // 2x scaled address; all operands widened to 18 bits before the multiply.
    assign vid_addr   = 18'(drawY[9:1]) * 18'(FB_W) + 18'(drawX[9:1]);
    assign video_slot = vid_active & ~drawX[0];

`ifdef FRAME_ARB_BLANK_ONLY_EN
    assign sec_slot_free = ~vid_active;
`else
    assign sec_slot_free = ~video_slot;
`endif

    // Out-of-range requests never touch the RAM; reset suppresses any grant.
    assign sec_grant = (state == ISSUE) & ~oob_q & sec_slot_free & ~Reset;
    assign sec_state = state;

    // RAM address mux: video first, then secondary, else hold the last address.
    always_comb begin
        ram_addr = ram_addr_q;
        if (video_slot) begin
            ram_addr = vid_addr;
        end else if (sec_grant) begin
            ram_addr = sec_addr_q;
        end
    end

    // Secondary FSM next-state and handshake outputs.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        sec_ack    = 1'b0;
        sec_data   = sec_data_q;
        case (state)
            IDLE: begin
                // sec_ack is only ever high in CAPTURE, so it is low here.
                if (sec_req) begin
                    state_next = ISSUE;
                    accept     = 1'b1;
                end
            end
            ISSUE: begin
                if (oob_q || sec_grant) begin
                    state_next = CAPTURE;
                end
            end
            CAPTURE: begin
                state_next = IDLE;
                sec_ack    = 1'b1;
                sec_data   = oob_q ? 2'd0 : ram_data;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Secondary FSM state, latched request, held RAM address and held sec_data.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= IDLE;
            sec_addr_q <= 18'd0;
            oob_q      <= 1'b0;
            ram_addr_q <= 18'd0;
            sec_data_q <= 2'd0;
        end else begin
            state      <= state_next;
            ram_addr_q <= ram_addr;
            if (accept) begin
                sec_addr_q <= sec_addr;
                oob_q      <= ({1'b0, sec_addr} >= FB_SIZE);
            end
            if (state == CAPTURE) begin
                sec_data_q <= sec_data;
            end
        end
    end

    // Video pipeline: issue cycle, RAM cycle, then register the pixel.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            vid_v1    <= 1'b0;
            act_d1    <= 1'b0;
            vid_pixel <= 2'd0;
        end else begin
            vid_v1 <= video_slot;
            act_d1 <= vid_active;
            if (!act_d1) begin
                vid_pixel <= 2'd0;
            end else if (vid_v1) begin
                vid_pixel <= ram_data;
            end
        end
    end

endmodule
